code_nco_gen: RTL and testbench

Local code replica generator for the code-tracking loop. It takes the loop correction word produced by the DLL and adds it to a nominal code rate to drive a code NCO. From that NCO it generates GPS C/A Gold-code early, prompt and late replicas at half-chip spacing, which feed the correlators whose outputs return to the DLL. It also emits a 1 ms code-epoch strobe and the current chip index for dump timing.

---
 rtl/code_nco_gen_if.sv | 24 ++
 rtl/code_nco_gen.sv | 152 +++++++++++++++
 tb/tb_code_nco_gen.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/code_nco_gen_if.sv
// Control and replica-output bundle between the DLL/correlator side and the
// code NCO replica generator.
interface code_nco_gen_if;
    logic               en;
    logic               restart;
    logic [4:0]         prn;
    logic signed [31:0] correction;
    logic               corr_valid;
    logic               early;
    logic               prompt;
    logic               late;
    logic [9:0]         chip_index;
    logic               epoch;

    modport master (
        output en, restart, prn, correction, corr_valid,
        input  early, prompt, late, chip_index, epoch
    );

    modport slave (
        input  en, restart, prn, correction, corr_valid,
        output early, prompt, late, chip_index, epoch
    );
endinterface

// File: rtl/code_nco_gen.sv
// Code NCO and GPS C/A Gold-code replica generator: produces early/prompt/late
// chips at half-chip spacing, the chip index and a code-epoch strobe.
module code_nco_gen #(
    parameter int                 PHASE_W     = 32,
    parameter logic [PHASE_W-1:0] NOMINAL_FCW = 32'd536870912,
    parameter logic [PHASE_W-1:0] FCW_MAX     = 32'h8000_0000
) (
    input  logic           clk,
    input  logic           rst,
    code_nco_gen_if.slave  bus
);

    logic [PHASE_W-1:0]        acc;
    logic [PHASE_W-1:0]        fcw;
    logic                      half;
    logic [10:1]               g1;
    logic [10:1]               g2;
    logic [4:0]                prn_q;
    logic [9:0]                chip_index_p1;
    logic                      early_p1;
    logic                      prompt_p1;
    logic                      late_p1;
    logic                      epoch_p1;

    logic signed [PHASE_W+1:0] fcw_sum;
    logic [PHASE_W:0]          nco_sum;
    logic                      tick;
    logic [7:0]                taps;
    logic                      g1_fb;
    logic                      g2_fb;
    logic                      code_chip;

    // Clamp the corrected control word into [0, FCW_MAX].
    function automatic logic [PHASE_W-1:0] sat_fcw(input logic signed [PHASE_W+1:0] s);
        if (s < 0)
            return '0;
        else if (s > $signed({2'b00, FCW_MAX}))
            return FCW_MAX;
        else
            return s[PHASE_W-1:0];
    endfunction

    // G2 phase-selector pair {s1, s2} for PRN 1..32 (prn code 0..31).
    function automatic logic [7:0] g2_taps(input logic [4:0] p);
        logic [7:0] t;
        t = {4'd2, 4'd6};
        case (p)
            5'd0:  t = {4'd2, 4'd6};
            5'd1:  t = {4'd3, 4'd7};
            5'd2:  t = {4'd4, 4'd8};
            5'd3:  t = {4'd5, 4'd9};
            5'd4:  t = {4'd1, 4'd9};
            5'd5:  t = {4'd2, 4'd10};
            5'd6:  t = {4'd1, 4'd8};
            5'd7:  t = {4'd2, 4'd9};
            5'd8:  t = {4'd3, 4'd10};
            5'd9:  t = {4'd2, 4'd3};
            5'd10: t = {4'd3, 4'd4};
            5'd11: t = {4'd5, 4'd6};
            5'd12: t = {4'd6, 4'd7};
            5'd13: t = {4'd7, 4'd8};
            5'd14: t = {4'd8, 4'd9};
            5'd15: t = {4'd9, 4'd10};
            5'd16: t = {4'd1, 4'd4};
            5'd17: t = {4'd2, 4'd5};
            5'd18: t = {4'd3, 4'd6};
            5'd19: t = {4'd4, 4'd7};
            5'd20: t = {4'd5, 4'd8};
            5'd21: t = {4'd6, 4'd9};
            5'd22: t = {4'd1, 4'd3};
            5'd23: t = {4'd4, 4'd6};
            5'd24: t = {4'd5, 4'd7};
            5'd25: t = {4'd6, 4'd8};
            5'd26: t = {4'd7, 4'd9};
            5'd27: t = {4'd8, 4'd10};
            5'd28: t = {4'd1, 4'd6};
            5'd29: t = {4'd2, 4'd7};
            5'd30: t = {4'd3, 4'd8};
            5'd31: t = {4'd4, 4'd9};
            default: t = {4'd2, 4'd6};
        endcase
        return t;
    endfunction

    // NCO carry, LFSR feedback and current Gold-code chip.
    always_comb begin
        fcw_sum   = $signed({2'b00, NOMINAL_FCW})
                  + $signed({{(PHASE_W-30){bus.correction[31]}}, bus.correction});
        nco_sum   = {1'b0, acc} + {1'b0, fcw};
        tick      = bus.en & nco_sum[PHASE_W];
        taps      = g2_taps(prn_q);
        g1_fb     = g1[3] ^ g1[10];
        g2_fb     = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
        code_chip = g1[10] ^ g2[taps[7:4]] ^ g2[taps[3:0]];
    end

    // Frequency control word: nominal on reset, loop-corrected on corr_valid;
    // a restart deliberately leaves it untouched.
    always_ff @(posedge clk) begin
        if (!rst)
            fcw <= NOMINAL_FCW;
        else if (bus.corr_valid)
            fcw <= sat_fcw(fcw_sum);
    end

    // Phase accumulator, code generators and registered replica outputs.
    always_ff @(posedge clk) begin
        if (!rst || bus.restart) begin
            acc           <= '0;
            half          <= 1'b0;
            g1            <= '1;
            g2            <= '1;
            chip_index_p1 <= '0;
            early_p1      <= 1'b0;
            prompt_p1     <= 1'b0;
            late_p1       <= 1'b0;
            epoch_p1      <= 1'b0;
            prn_q         <= bus.prn;
        end else begin
            epoch_p1 <= 1'b0;
            if (bus.en) begin
                // Overflow wraps; residual phase is kept across the tick.
                acc <= nco_sum[PHASE_W-1:0];
            end
            if (tick) begin
                late_p1   <= prompt_p1;
                prompt_p1 <= early_p1;
                early_p1  <= code_chip;
                half      <= ~half;
                if (half) begin
                    if (chip_index_p1 == 10'd1022) begin
                        chip_index_p1 <= '0;
                        g1            <= '1;
                        g2            <= '1;
                        epoch_p1      <= 1'b1;
                    end else begin
                        chip_index_p1 <= chip_index_p1 + 10'd1;
                        g1            <= {g1[9:1], g1_fb};
                        g2            <= {g2[9:1], g2_fb};
                    end
                end
            end
        end
    end

    assign bus.early      = early_p1;
    assign bus.prompt     = prompt_p1;
    assign bus.late       = late_p1;
    assign bus.chip_index = chip_index_p1;
    assign bus.epoch      = epoch_p1;

endmodule

// File: tb/tb_code_nco_gen.sv
// Bench for code_nco_gen: a tick-count reference model pushes the expected
// outputs for every clock into a queue; they are popped and compared after
// the edge, alongside direct checks of the known code prefixes and timing.
module tb_code_nco_gen;

    localparam longint NOM  = 64'd536870912;
    localparam longint FMAX = 64'd2147483648;
    localparam longint WRAP = 64'h1_0000_0000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    code_nco_gen_if bus ();

    code_nco_gen #(
        .PHASE_W     (32),
        .NOMINAL_FCW (32'd536870912),
        .FCW_MAX     (32'h8000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    longint      m_acc;
    longint      m_fcw;
    int          m_k;
    int          m_prn;
    bit          ctab [0:1022];
    logic [13:0] sbq [$];

    int s1t [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    int s2t [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void gen_code(input int p);
        bit a [1:10];
        bit b [1:10];
        bit fa;
        bit fb;
        for (int j = 1; j <= 10; j++) begin
            a[j] = 1'b1;
            b[j] = 1'b1;
        end
        for (int i = 0; i < 1023; i++) begin
            ctab[i] = a[10] ^ b[s1t[p]] ^ b[s2t[p]];
            fa = a[3] ^ a[10];
            fb = b[2] ^ b[3] ^ b[6] ^ b[8] ^ b[9] ^ b[10];
            for (int j = 10; j >= 2; j--) begin
                a[j] = a[j-1];
                b[j] = b[j-1];
            end
            a[1] = fa;
            b[1] = fb;
        end
    endfunction

    // Outputs after m_k half-chip ticks since the last reset/restart.
    function automatic logic [13:0] model_out(input bit tick);
        logic       e;
        logic       p;
        logic       l;
        logic       ep;
        logic [9:0] ci;
        e  = (m_k >= 1) ? ctab[((m_k - 1) / 2) % 1023] : 1'b0;
        p  = (m_k >= 2) ? ctab[((m_k - 2) / 2) % 1023] : 1'b0;
        l  = (m_k >= 3) ? ctab[((m_k - 3) / 2) % 1023] : 1'b0;
        ci = 10'((m_k / 2) % 1023);
        ep = tick && (m_k % 2 == 0) && ((m_k / 2) % 1023 == 0);
        return {e, p, l, ep, ci};
    endfunction

    // One clock: advance the model with the current inputs, then compare.
    task automatic cyc();
        longint s;
        longint nf;
        bit     tick;
        tick = 1'b0;
        nf   = m_fcw;
        if (!rst) begin
            m_acc = 0;
            m_k   = 0;
            nf    = NOM;
            m_prn = int'(bus.prn);
            gen_code(m_prn);
        end else begin
            if (bus.corr_valid) begin
                s  = NOM + longint'(bus.correction);
                nf = (s < 0) ? 0 : ((s > FMAX) ? FMAX : s);
            end
            if (bus.restart) begin
                m_acc = 0;
                m_k   = 0;
                m_prn = int'(bus.prn);
                gen_code(m_prn);
            end else if (bus.en) begin
                s     = m_acc + m_fcw;
                tick  = (s >= WRAP);
                m_acc = s % WRAP;
                if (tick) m_k++;
            end
        end
        m_fcw = nf;
        sbq.push_back(model_out(tick));
        @(posedge clk);
        #1;
        check("outs", 32'({bus.early, bus.prompt, bus.late, bus.epoch, bus.chip_index}),
              32'(sbq.pop_front()));
    endtask

    initial begin
        logic [9:0] cap;
        int         ci;
        int         ep [$];
        bit         hist [$];
        logic [9:0] held_idx;
        logic [2:0] held_epl;

        m_acc = 0; m_fcw = NOM; m_k = 0; m_prn = 0;
        rst            = 1'b0;
        bus.en         = 1'b0;
        bus.restart    = 1'b0;
        bus.prn        = 5'd0;
        bus.correction = 32'sd0;
        bus.corr_valid = 1'b0;

        // Reset, with a correction offered that must be ignored
        cyc();
        bus.corr_valid = 1'b1;
        bus.correction = 32'sh7FFF_FFFF;
        cyc();
        bus.corr_valid = 1'b0;
        bus.correction = 32'sd0;
        cyc();
        check("rst_early", 32'(bus.early), 32'd0);
        check("rst_prompt", 32'(bus.prompt), 32'd0);
        check("rst_late", 32'(bus.late), 32'd0);
        check("rst_chip_index", 32'(bus.chip_index), 32'd0);
        check("rst_epoch", 32'(bus.epoch), 32'd0);

        // PRN1 at nominal rate over two epochs
        rst    = 1'b1;
        bus.en = 1'b1;
        cap    = '0;
        ci     = 0;
        for (int j = 1; j <= 32736 + 20; j++) begin
            if (j == 1000) bus.prn = 5'd4;   // no effect outside reset/restart
            cyc();
            if (j == 7) check("prn1_before_first_tick", 32'(bus.early), 32'd0);
            if (j >= 8 && (j - 8) % 16 == 0 && ci < 10) begin
                cap = {cap[8:0], bus.early};
                ci++;
            end
            if (bus.epoch) ep.push_back(j);
        end
        check("prn1_first10", 32'(cap), 32'(10'b1100100000));
        check("epoch_count", 32'(ep.size()), 32'd2);
        if (ep.size() >= 1) check("epoch_first", 32'(ep[0]), 32'd16368);
        if (ep.size() >= 2) check("epoch_period", 32'(ep[1] - ep[0]), 32'd16368);

        // PRN2: early/prompt/late spacing over a full epoch
        rst     = 1'b0;
        bus.prn = 5'd1;
        cyc();
        rst = 1'b1;
        cap = '0;
        ci  = 0;
        for (int j = 1; j <= 16400; j++) begin
            cyc();
            hist.push_back(bus.early);
            if (j >= 8 && (j - 8) % 16 == 0 && ci < 10) begin
                cap = {cap[8:0], bus.early};
                ci++;
            end
            if (j > 16)
                check("epl_spacing", 32'({bus.prompt, bus.late}),
                      32'({hist[j-1-8], hist[j-1-16]}));
        end
        check("prn2_first10", 32'(cap), 32'(10'b1110010000));

        // Correction +2^29: fcw = 2^30, four clocks per half-chip tick
        bus.corr_valid = 1'b1;
        bus.correction = 32'sh2000_0000;
        cyc();
        bus.corr_valid = 1'b0;
        for (int j = 0; j < 200; j++) cyc();

        // Correction -2^30: saturates at 0, the code freezes
        bus.corr_valid = 1'b1;
        bus.correction = -32'sh4000_0000;
        cyc();
        bus.corr_valid = 1'b0;
        cyc();
        held_idx = bus.chip_index;
        held_epl = {bus.early, bus.prompt, bus.late};
        for (int j = 0; j < 100; j++) cyc();
        check("frozen_chip_index", 32'(bus.chip_index), 32'(held_idx));
        check("frozen_epl", 32'({bus.early, bus.prompt, bus.late}), 32'(held_epl));

        // Largest positive correction: clamps to FCW_MAX, a tick every 2 clocks
        bus.corr_valid = 1'b1;
        bus.correction = 32'sh7FFF_FFFF;
        cyc();
        bus.corr_valid = 1'b0;
        for (int j = 0; j < 203; j++) cyc();

        // en=0 for 100 cycles holds everything
        bus.en = 1'b0;
        held_idx = bus.chip_index;
        held_epl = {bus.early, bus.prompt, bus.late};
        for (int j = 0; j < 100; j++) cyc();
        check("en_hold_chip_index", 32'(bus.chip_index), 32'(held_idx));
        check("en_hold_epl", 32'({bus.early, bus.prompt, bus.late}), 32'(held_epl));
        bus.en = 1'b1;
        for (int j = 0; j < 50; j++) cyc();

        // Restart mid-epoch with a new PRN; FCW_MAX is kept
        bus.restart = 1'b1;
        bus.prn     = 5'd2;
        cyc();
        bus.restart = 1'b0;
        check("restart_chip_index", 32'(bus.chip_index), 32'd0);
        check("restart_early", 32'(bus.early), 32'd0);
        for (int j = 0; j < 300; j++) cyc();

        // Restart together with a correction back to nominal
        bus.restart    = 1'b1;
        bus.corr_valid = 1'b1;
        bus.correction = 32'sd0;
        cyc();
        bus.restart    = 1'b0;
        bus.corr_valid = 1'b0;
        for (int j = 0; j < 100; j++) cyc();

        // Speed up, then reset mid-epoch: outputs clear, fcw returns to nominal
        bus.corr_valid = 1'b1;
        bus.correction = 32'sh1000_0000;
        cyc();
        bus.corr_valid = 1'b0;
        for (int j = 0; j < 77; j++) cyc();
        rst = 1'b0;
        cyc();
        check("midrst_chip_index", 32'(bus.chip_index), 32'd0);
        check("midrst_epl", 32'({bus.early, bus.prompt, bus.late, bus.epoch}), 32'd0);
        rst = 1'b1;
        for (int j = 0; j < 150; j++) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
